// File: rtl/band_power_window.sv
// Mean power (mean of y^2) over non-overlapping windows of 2**WIN_LOG2 accepted samples.
// Raises a sustained-event alert once HOLD consecutive windows exceed the threshold.
module band_power_window #(
    parameter int DATA_W   = 32,
    parameter int WIN_LOG2 = 8,
    parameter int HOLD     = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic signed [DATA_W-1:0]   y_in,
    input  logic [2*DATA_W-1:0]        thresh,
    output logic [2*DATA_W-1:0]        power,
    output logic                       power_vld,
    output logic                       above,
    output logic                       alert,
    output logic [WIN_LOG2-1:0]        win_cnt
);

    localparam int SQ_W  = 2 * DATA_W;
    localparam int ACC_W = SQ_W + WIN_LOG2;
    localparam int RUN_W = $clog2(HOLD + 1);

    localparam logic [WIN_LOG2-1:0] WIN_MAX = '1;
    localparam logic [RUN_W-1:0]    HOLD_R  = RUN_W'(HOLD);
    localparam logic [RUN_W-1:0]    RUN_ONE = RUN_W'(1);

    typedef enum logic [1:0] {
        S_QUIET,
        S_ARMING,
        S_ALERT
    } state_t;

    logic signed [SQ_W-1:0] w_ySqSigned;
    logic [SQ_W-1:0]        w_ySq;
    logic [ACC_W-1:0]       w_accSum;
    logic [SQ_W-1:0]        w_mean;
    logic                   w_close;
    logic                   w_aboveNow;

    logic [SQ_W-1:0]        r_sq;
    logic                   r_sqVld;
    logic                   r_sqLast;
    logic [WIN_LOG2-1:0]    r_winCnt;
    logic [ACC_W-1:0]       r_acc;
    logic [SQ_W-1:0]        r_power;
    logic                   r_powerVld;
    logic                   r_above;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [RUN_W-1:0]       r_run;
    logic [RUN_W-1:0]       w_runNext;

    // Both operands are signed, so they are extended to SQ_W before the multiply and the
    // square is exact; it is never negative, hence safe to reinterpret as unsigned.
    assign w_ySqSigned = y_in * y_in;
    assign w_ySq       = $unsigned(w_ySqSigned);

    assign w_accSum    = r_acc + {{WIN_LOG2{1'b0}}, r_sq};
    assign w_mean      = w_accSum[ACC_W-1:WIN_LOG2];
    assign w_close     = r_sqVld & r_sqLast;
    assign w_aboveNow  = (w_mean > thresh);

    // Stage 1: square the accepted sample and tag the window's last sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sq     <= '0;
            r_sqVld  <= 1'b0;
            r_sqLast <= 1'b0;
            r_winCnt <= '0;
        end else begin
            r_sqVld <= in_valid;
            if (in_valid) begin
                r_sq     <= w_ySq;
                r_sqLast <= (r_winCnt == WIN_MAX);
                r_winCnt <= r_winCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_power    <= '0;
            r_powerVld <= 1'b0;
            r_above    <= 1'b0;
        end else begin
            r_powerVld <= w_close;
            if (r_sqVld) begin
                if (r_sqLast) begin
                    r_acc   <= '0;
                    r_power <= w_mean;
                    r_above <= w_aboveNow;
                end else begin
                    r_acc   <= w_accSum;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_QUIET;
            r_run   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_run   <= w_runNext;
        end
    end

    // The detector only moves on window close, using the freshly computed comparison
    // so that alert changes on the same edge that raises power_vld.
    always_comb begin
        w_stateNext = r_state;
        w_runNext   = r_run;
        if (w_close) begin
            case (r_state)
                S_QUIET: begin
                    if (w_aboveNow) begin
                        w_runNext   = RUN_ONE;
                        w_stateNext = (HOLD == 1) ? S_ALERT : S_ARMING;
                    end else begin
                        w_runNext   = '0;
                    end
                end
                S_ARMING: begin
                    if (w_aboveNow) begin
                        w_runNext = r_run + 1'b1;
                        if (r_run + 1'b1 == HOLD_R) begin
                            w_stateNext = S_ALERT;
                        end
                    end else begin
                        w_stateNext = S_QUIET;
                        w_runNext   = '0;
                    end
                end
                S_ALERT: begin
                    if (!w_aboveNow) begin
                        w_stateNext = S_QUIET;
                        w_runNext   = '0;
                    end
                end
                default: begin
                    w_stateNext = S_QUIET;
                    w_runNext   = '0;
                end
            endcase
        end
    end

    assign power     = r_power;
    assign power_vld = r_powerVld;
    assign above     = r_above;
    assign alert     = (r_state == S_ALERT);
    assign win_cnt   = r_winCnt;

endmodule

// File: tb/tb_band_power_window.sv
// Randomized and directed bench for band_power_window: a window-level reference model
// pushes expected results into a queue that an independent monitor pops on power_vld.
module tb_band_power_window;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [31:0] y_in = '0;
    logic [63:0]        thresh = '1;
    logic [63:0]        power;
    logic               power_vld;
    logic               above;
    logic               alert;
    logic [7:0]         win_cnt;

    typedef struct {
        logic [63:0] power;
        logic        above;
        logic        alert;
        int          cyc;
    } want_t;

    want_t   expQ[$];
    longint  winSamples[$];
    int      run = 0;
    int      cyc = 0;
    int      total = 0;
    int      bad = 0;

    logic [63:0] hPower = '0;
    logic        hAbove = 1'b0;
    logic        hAlert = 1'b0;

    band_power_window #(.DATA_W(32), .WIN_LOG2(8), .HOLD(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .y_in      (y_in),
        .thresh    (thresh),
        .power     (power),
        .power_vld (power_vld),
        .above     (above),
        .alert     (alert),
        .win_cnt   (win_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Mean power of a full window from the raw samples, plus the consecutive-run rule.
    task automatic closeWindow();
        logic [127:0] sum;
        want_t        w;
        sum = '0;
        foreach (winSamples[i]) sum += 128'(winSamples[i] * winSamples[i]);
        w.power = sum[71:8];
        w.above = (w.power > thresh);
        run     = w.above ? run + 1 : 0;
        w.alert = (run >= 3);
        w.cyc   = cyc + 2;
        expQ.push_back(w);
        winSamples.delete();
    endtask

    task automatic applyStimulus(input bit v, input logic signed [31:0] y);
        @(negedge clk);
        in_valid = v;
        y_in     = y;
        if (v) begin
            winSamples.push_back(longint'(y));
            if (winSamples.size() == 256) closeWindow();
        end
        @(posedge clk);
        #1;
        checkOutput("win_cnt", 64'(win_cnt), 64'(winSamples.size()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'sd0);
    endtask

    task automatic window(input logic signed [31:0] y);
        for (int i = 0; i < 256; i++) applyStimulus(1'b1, y);
    endtask

    task automatic setThresh(input logic [63:0] t);
        idle(1);
        thresh = t;
    endtask

    task automatic doReset(input int n);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        winSamples.delete();
        run = 0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: samples just after each rising edge, independent of the stimulus process.
    initial begin
        want_t w;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                expQ.delete();
                hPower = '0;
                hAbove = 1'b0;
                hAlert = 1'b0;
                checkOutput("rst_power", power, 64'd0);
                checkOutput("rst_power_vld", 64'(power_vld), 64'd0);
                checkOutput("rst_above", 64'(above), 64'd0);
                checkOutput("rst_alert", 64'(alert), 64'd0);
                checkOutput("rst_win_cnt", 64'(win_cnt), 64'd0);
            end else begin
                if (!power_vld && expQ.size() > 0 && expQ[0].cyc <= cyc) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL pulse_missing: got no power_vld at cycle %0d, expected at cycle %0d", cyc, expQ[0].cyc);
                    w = expQ.pop_front();
                    hPower = w.power;
                    hAbove = w.above;
                    hAlert = w.alert;
                end
                if (power_vld) begin
                    if (expQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL pulse_unexpected: got power_vld=1 at cycle %0d, expected none", cyc);
                    end else begin
                        w = expQ.pop_front();
                        checkOutput("pulse_cycle", 64'(cyc), 64'(w.cyc));
                        hPower = w.power;
                        hAbove = w.above;
                        hAlert = w.alert;
                    end
                end
                checkOutput("power", power, hPower);
                checkOutput("above", 64'(above), 64'(hAbove));
                checkOutput("alert", 64'(alert), 64'(hAlert));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no completion by %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic signed [31:0] r;
        int                 shift;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        window(32'sd1000);
        idle(3);

        for (int i = 0; i < 256; i++) applyStimulus(1'b1, (i % 2 == 0) ? 32'sd1000 : -32'sd1000);
        idle(2);
        window(32'sh8000_0000);
        idle(3);

        setThresh(64'd500_000);
        window(32'sd1000);
        window(32'sd1000);
        window(32'sd1000);
        window(32'sd0);
        idle(3);

        setThresh(64'd1_000_000);
        window(32'sd1000);
        window(32'sd1001);
        idle(3);

        for (int i = 0; i < 512; i++) applyStimulus(i % 2 == 0, 32'sd777);
        idle(3);

        for (int i = 0; i < 100; i++) applyStimulus(1'b1, 32'sd1000);
        doReset(2);
        window(32'sd10);
        idle(3);

        window(32'sd500);
        doReset(2);
        idle(3);

        for (int k = 0; k < 8; k++) begin
            shift = $urandom_range(0, 30);
            for (int i = 0; i < 256; i++) begin
                if (i == 128) begin
                    case ($urandom_range(0, 3))
                        0:       thresh = 64'd0;
                        1:       thresh = '1;
                        default: thresh = {$urandom(), $urandom()} >> (2 * shift + 2);
                    endcase
                end
                if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, 32'sd0);
                r = $urandom();
                applyStimulus(1'b1, r >>> shift);
            end
        end
        idle(2);

        for (int i = 0; i < 50 && expQ.size() > 0; i++) @(negedge clk);
        if (expQ.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending results, expected 0", expQ.size());
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
